// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: parity modes, frame-checker states
// and the parity-error helper.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } state_t;

  // Codes 5-7 behave as "no parity".
  function automatic par_mode_t decode_par_mode(input logic [2:0] raw);
    case (raw)
      3'd1:    return PAR_EVEN;
      3'd2:    return PAR_ODD;
      3'd3:    return PAR_MARK;
      3'd4:    return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic parity_error(input par_mode_t mode, input logic p, input logic b);
    case (mode)
      PAR_EVEN:  return p ^ b;
      PAR_ODD:   return ~(p ^ b);
      PAR_MARK:  return ~b;
      PAR_SPACE: return b;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_checker_if.sv
// Bit-stream in / frame report out between the receiver bit-timing logic and the
// frame checker.
interface uart_frame_checker_if #(parameter int MAX_DATA_WIDTH = 8);
  logic                      frame_start;
  logic                      bit_valid;
  logic                      sampled_bit;
  logic [MAX_DATA_WIDTH-1:0] rx_data;
  logic                      frame_done;
  logic                      par_err;
  logic                      stop_err;

  modport master (output frame_start, bit_valid, sampled_bit,
                  input  rx_data, frame_done, par_err, stop_err);
  modport slave  (input  frame_start, bit_valid, sampled_bit,
                  output rx_data, frame_done, par_err, stop_err);
endinterface

// File: rtl/uart_err_counter.sv
// Saturating error counter; a clear and an increment in the same cycle yield 1.
module uart_err_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] base;

  assign base = clr ? '0 : count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (base != '1)) begin
      count <= base + CNT_WIDTH'(1);
    end else begin
      count <= base;
    end
  end

endmodule

// File: rtl/uart_frame_checker.sv
// UART receive frame checker: assembles data bits, checks parity and stop bits,
// reports per-frame errors and keeps sticky flags and saturating counters.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for frame_start
// ST_DATA   | shifting in data_len data bits
// ST_PARITY | waiting for the parity bit (parity enabled)
// ST_STOP1  | waiting for the first stop bit
// ST_STOP2  | waiting for the second stop bit (two stops)
module uart_frame_checker
  import uart_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  uart_frame_checker_if.slave               rx,
  input  logic [$clog2(MAX_DATA_WIDTH):0]   data_len,
  input  logic [2:0]                        par_mode,
  input  logic                              stop_bits,
  input  logic                              clr_stat,
  output logic                              par_err_sticky,
  output logic                              stop_err_sticky,
  output logic [CNT_WIDTH-1:0]              par_err_cnt,
  output logic [CNT_WIDTH-1:0]              stop_err_cnt,
  output logic                              busy
);

  localparam int LW = $clog2(MAX_DATA_WIDTH) + 1;
  localparam int IW = $clog2(MAX_DATA_WIDTH);

  state_t                    state, state_nxt;
  logic                      start, abort, bit_accept, par_check, stop1_check, report;
  logic [LW-1:0]             eff_len, len_q;
  logic [IW-1:0]             bit_index, last_index;
  logic [MAX_DATA_WIDTH-1:0] data_reg;
  par_mode_t                 mode_q;
  logic                      stop2_q, par_acc, par_err_acc, stop_acc, stop_err_now;
  logic                      frame_done_q, par_err_q, stop_err_q;

  assign start        = enable & rx.frame_start;
  assign eff_len      = ((data_len == '0) || (data_len > LW'(MAX_DATA_WIDTH))) ?
                        LW'(MAX_DATA_WIDTH) : data_len;
  assign last_index   = IW'(len_q - LW'(1));
  assign stop_err_now = stop_acc | ~rx.sampled_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Disable and restart take priority over any bit strobe in the same cycle.
  always_comb begin
    state_nxt   = state;
    abort       = 1'b0;
    bit_accept  = 1'b0;
    par_check   = 1'b0;
    stop1_check = 1'b0;
    report      = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      abort     = (state != ST_IDLE);
    end else if (rx.frame_start) begin
      state_nxt = ST_DATA;
      abort     = (state != ST_IDLE);
    end else if (rx.bit_valid) begin
      case (state)
        ST_DATA: begin
          bit_accept = 1'b1;
          if (bit_index == last_index)
            state_nxt = (mode_q == PAR_NONE) ? ST_STOP1 : ST_PARITY;
        end
        ST_PARITY: begin
          par_check = 1'b1;
          state_nxt = ST_STOP1;
        end
        ST_STOP1: begin
          stop1_check = 1'b1;
          if (stop2_q) begin
            state_nxt = ST_STOP2;
          end else begin
            state_nxt = ST_IDLE;
            report    = 1'b1;
          end
        end
        ST_STOP2: begin
          state_nxt = ST_IDLE;
          report    = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg     <= '0;
      bit_index    <= '0;
      len_q        <= '0;
      mode_q       <= PAR_NONE;
      stop2_q      <= 1'b0;
      par_acc      <= 1'b0;
      par_err_acc  <= 1'b0;
      stop_acc     <= 1'b0;
      frame_done_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      frame_done_q <= report;
      if (abort) begin
        par_err_q  <= 1'b0;
        stop_err_q <= 1'b0;
      end
      if (report) begin
        par_err_q  <= par_err_acc;
        stop_err_q <= stop_err_now;
      end
      if (start) begin
        data_reg    <= '0;
        bit_index   <= '0;
        len_q       <= eff_len;
        mode_q      <= decode_par_mode(par_mode);
        stop2_q     <= stop_bits;
        par_acc     <= 1'b0;
        par_err_acc <= 1'b0;
        stop_acc    <= 1'b0;
      end else if (bit_accept) begin
        data_reg[bit_index] <= rx.sampled_bit;
        bit_index           <= bit_index + IW'(1);
        par_acc             <= par_acc ^ rx.sampled_bit;
      end
      if (par_check)   par_err_acc <= parity_error(mode_q, par_acc, rx.sampled_bit);
      if (stop1_check) stop_acc    <= ~rx.sampled_bit;
    end
  end

  // Clear first, then let a same-cycle erroring report set the flag again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_err_sticky  <= 1'b0;
      stop_err_sticky <= 1'b0;
    end else begin
      if (clr_stat) begin
        par_err_sticky  <= 1'b0;
        stop_err_sticky <= 1'b0;
      end
      if (report && par_err_acc)  par_err_sticky  <= 1'b1;
      if (report && stop_err_now) stop_err_sticky <= 1'b1;
    end
  end

  uart_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_stat),
    .inc     (report & par_err_acc),
    .count   (par_err_cnt)
  );

  uart_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_stat),
    .inc     (report & stop_err_now),
    .count   (stop_err_cnt)
  );

  assign busy          = (state != ST_IDLE);
  assign rx.rx_data    = data_reg;
  assign rx.frame_done = frame_done_q;
  assign rx.par_err    = par_err_q;
  assign rx.stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_frame_checker.sv
// Directed frames for the UART frame checker; expected reports are queued by the
// stimulus and checked by an independent monitor on every frame_done.
module tb_uart_frame_checker;

  localparam int MAXW = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic [3:0]    data_len = 4'd8;
  logic [2:0]    par_mode = 3'd0;
  logic          stop_bits = 1'b0;
  logic          clr_stat = 1'b0;
  logic          par_err_sticky, stop_err_sticky, busy;
  logic [CW-1:0] par_err_cnt, stop_err_cnt;

  uart_frame_checker_if #(.MAX_DATA_WIDTH(MAXW)) rx_if ();

  uart_frame_checker #(.MAX_DATA_WIDTH(MAXW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .rx              (rx_if),
    .data_len        (data_len),
    .par_mode        (par_mode),
    .stop_bits       (stop_bits),
    .clr_stat        (clr_stat),
    .par_err_sticky  (par_err_sticky),
    .stop_err_sticky (stop_err_sticky),
    .par_err_cnt     (par_err_cnt),
    .stop_err_cnt    (stop_err_cnt),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit pe;
    bit se;
    int pc;
    int sc;
    bit ps;
    bit ss;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pc = 0, m_sc = 0;
  bit   m_ps = 0, m_ss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_pc = 0; m_sc = 0; m_ps = 0; m_ss = 0;
  endtask

  task automatic expect_frame(input int d, input bit pe, input bit se, input bit clr);
    exp_t e;
    if (clr) model_clear();
    if (pe) begin m_ps = 1; if (m_pc < CMAX) m_pc++; end
    if (se) begin m_ss = 1; if (m_sc < CMAX) m_sc++; end
    e = '{d, pe, se, m_pc, m_sc, m_ps, m_ss};
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && rx_if.frame_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got rx_data %0h expected no report at %0t",
                 rx_if.rx_data, $time);
      end else begin
        e = sb.pop_front();
        chk("rx_data",         32'(rx_if.rx_data),   32'(e.data));
        chk("par_err",         32'(rx_if.par_err),   32'(e.pe));
        chk("stop_err",        32'(rx_if.stop_err),  32'(e.se));
        chk("par_err_cnt",     32'(par_err_cnt),     32'(e.pc));
        chk("stop_err_cnt",    32'(stop_err_cnt),    32'(e.sc));
        chk("par_err_sticky",  32'(par_err_sticky),  32'(e.ps));
        chk("stop_err_sticky", 32'(stop_err_sticky), 32'(e.ss));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rx_data"},    32'(rx_if.rx_data),    0);
    chk({tag, "_frame_done"}, 32'(rx_if.frame_done), 0);
    chk({tag, "_par_err"},    32'(rx_if.par_err),    0);
    chk({tag, "_stop_err"},   32'(rx_if.stop_err),   0);
    chk({tag, "_par_sticky"}, 32'(par_err_sticky),   0);
    chk({tag, "_stop_sticky"},32'(stop_err_sticky),  0);
    chk({tag, "_par_cnt"},    32'(par_err_cnt),      0);
    chk({tag, "_stop_cnt"},   32'(stop_err_cnt),     0);
    chk({tag, "_busy"},       32'(busy),             0);
  endtask

  task automatic send_bit(input logic b, input bit last, input bit clr);
    tick();
    if (last) chk("done_early", 32'(rx_if.frame_done), 0);
    rx_if.bit_valid   = 1'b1;
    rx_if.sampled_bit = b;
    clr_stat          = clr;
    tick();
    rx_if.bit_valid = 1'b0;
    clr_stat        = 1'b0;
    if (last) chk("done_latency", 32'(rx_if.frame_done), 1);
  endtask

  task automatic do_start(input int len_cfg, input int mode, input bit two, input bit coinc);
    data_len          = 4'(len_cfg);
    par_mode          = 3'(mode);
    stop_bits         = two;
    rx_if.frame_start = 1'b1;
    if (coinc) begin
      rx_if.bit_valid   = 1'b1;
      rx_if.sampled_bit = 1'b1;
    end
    tick();
    rx_if.frame_start = 1'b0;
    rx_if.bit_valid   = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    // Scramble the configuration: the frame must use the values latched at start.
    data_len  = 4'd5;
    par_mode  = 3'd1;
    stop_bits = ~two;
  endtask

  task automatic send_frame(input int len_cfg, input int mode, input bit two, input int nd,
                            input logic [7:0] d, input bit has_par, input bit pb,
                            input bit s1, input bit s2, input bit clr_last, input bit coinc);
    do_start(len_cfg, mode, two, coinc);
    for (int i = 0; i < nd; i++) send_bit(d[i], 1'b0, 1'b0);
    if (has_par) send_bit(pb, 1'b0, 1'b0);
    if (two) begin
      send_bit(s1, 1'b0, 1'b0);
      send_bit(s2, 1'b1, clr_last);
    end else begin
      send_bit(s1, 1'b1, clr_last);
    end
  endtask

  task automatic start_partial(input int nd, input logic [7:0] d);
    do_start(8, 0, 1'b0, 1'b0);
    for (int i = 0; i < nd; i++) send_bit(d[i], 1'b0, 1'b0);
  endtask

  initial begin
    rx_if.frame_start = 1'b0;
    rx_if.bit_valid   = 1'b0;
    rx_if.sampled_bit = 1'b1;
    #2;
    chk_zero("reset");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Strobes while idle are ignored.
    rx_if.bit_valid = 1'b1;
    rx_if.sampled_bit = 1'b0;
    tick();
    rx_if.bit_valid = 1'b0;
    chk("idle_bit_busy", 32'(busy), 0);

    // 8N1 0xA5
    expect_frame(8'hA5, 0, 0, 0);
    send_frame(8, 0, 0, 8, 8'hA5, 0, 0, 1, 1, 0, 0);
    // 7E1 0x35: four ones -> XOR 0, parity bit sent 1 -> error
    expect_frame(8'h35, 1, 0, 0);
    send_frame(7, 1, 0, 7, 8'h35, 1, 1, 1, 1, 0, 0);
    // good frame keeps the parity sticky flag
    expect_frame(8'h5A, 0, 0, 0);
    send_frame(8, 0, 0, 8, 8'h5A, 0, 0, 1, 1, 0, 0);
    // 8O2 0x00, parity 1 (correct), second stop bit 0
    expect_frame(8'h00, 0, 1, 0);
    send_frame(8, 2, 1, 8, 8'h00, 1, 1, 1, 0, 0, 0);
    tick();
    chk("done_one_cycle", 32'(rx_if.frame_done), 0);
    chk("stop_err_hold",  32'(rx_if.stop_err),   1);
    // mark / space with 5-bit 0x1F and parity bit 0
    expect_frame(8'h1F, 1, 0, 0);
    send_frame(5, 3, 0, 5, 8'h1F, 1, 0, 1, 1, 0, 0);
    expect_frame(8'h1F, 0, 0, 0);
    send_frame(5, 4, 0, 5, 8'h1F, 1, 0, 1, 1, 0, 0);
    // data_len 0 means full width, par_mode 6 means none
    expect_frame(8'hC3, 0, 0, 0);
    send_frame(0, 6, 0, 8, 8'hC3, 0, 0, 1, 1, 0, 0);
    // restart mid-frame, then a full 0x3C frame
    start_partial(3, 8'hFF);
    expect_frame(8'h3C, 0, 0, 0);
    send_frame(8, 0, 0, 8, 8'h3C, 0, 0, 1, 1, 0, 0);
    // bit_valid coincident with frame_start is discarded
    expect_frame(8'h02, 0, 0, 0);
    send_frame(8, 0, 0, 8, 8'h02, 0, 0, 1, 1, 0, 1);

    // enable drop mid-frame aborts silently; frame_start ignored while disabled
    start_partial(4, 8'h0F);
    enable = 1'b0;
    tick();
    chk("disable_busy", 32'(busy), 0);
    rx_if.frame_start = 1'b1;
    tick();
    rx_if.frame_start = 1'b0;
    chk("disabled_start_busy", 32'(busy), 0);
    chk("disable_keeps_sticky", 32'(par_err_sticky), 1);
    enable = 1'b1;
    repeat (12) begin
      rx_if.bit_valid = 1'b1;
      rx_if.sampled_bit = 1'b1;
      tick();
      rx_if.bit_valid = 1'b0;
    end
    chk("after_disable_busy", 32'(busy), 0);

    // standalone clear
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    model_clear();
    chk("clr_par_cnt",    32'(par_err_cnt),     0);
    chk("clr_stop_cnt",   32'(stop_err_cnt),    0);
    chk("clr_par_sticky", 32'(par_err_sticky),  0);
    chk("clr_stop_sticky",32'(stop_err_sticky), 0);

    // saturate the stop error counter
    for (int n = 0; n < CMAX + 3; n++) begin
      expect_frame(8'h0A, 0, 1, 0);
      send_frame(5, 0, 0, 5, 8'h0A, 0, 0, 0, 1, 0, 0);
    end
    chk("stop_cnt_saturated", 32'(stop_err_cnt), CMAX);

    // clear coincident with an erroring report
    expect_frame(8'h0A, 0, 1, 1);
    send_frame(5, 0, 0, 5, 8'h0A, 0, 0, 0, 1, 1, 0);

    // async reset mid-frame
    start_partial(4, 8'hFF);
    reset_n = 1'b0;
    #2;
    chk_zero("midreset");
    tick();
    reset_n = 1'b1;
    model_clear();
    tick();
    expect_frame(8'h96, 0, 0, 0);
    send_frame(8, 0, 0, 8, 8'h96, 0, 0, 1, 1, 0, 0);

    repeat (5) tick();
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
